// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage state type and default widths for imem and top level
package fetch_unit_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
   localparam int DEF_PC_W  = 10;
   localparam int DEF_OFF_W = 7;
   localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, imem addressing and run/halt sequencing for the ARK core
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PC_W  = DEF_PC_W,
   parameter int OFF_W = DEF_OFF_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [PC_W-1:0]  start_addr,
   input  logic             branch,
   input  logic             halt,
   input  logic             cond_flag,
   input  logic [OFF_W-1:0] branch_off,
   output logic [PC_W-1:0]  imem_addr,
   output logic [PC_W-1:0]  pc,
   output logic             fetch_valid,
   output logic             done,
   output logic [CNT_W-1:0] instr_count
);
   fetch_state_t state;
   logic [PC_W-1:0] step;
   logic [PC_W-1:0] next_pc;
   // taken branch adds the sign-extended offset, otherwise advance by one; wraps modulo 2**PC_W
   always_comb begin
      step    = (branch && cond_flag) ? PC_W'(signed'(branch_off)) : PC_W'(1);
      next_pc = pc + step;
   end
   assign imem_addr   = pc;
   assign fetch_valid = (state == RUN);
   // run/halt sequencer with pc and saturating retired-instruction counter
   always_ff @(posedge CLK) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= '0;
         done        <= 1'b0;
         instr_count <= '0;
      end else begin
         case (state)
            RUN: begin
               if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
               if (halt) begin
                  state <= HALTED;
                  done  <= 1'b1;
               end else pc <= next_pc;
            end
            IDLE, HALTED: if (start) begin
               state       <= RUN;
               pc          <= start_addr;
               instr_count <= '0;
               done        <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a per-cycle integer model of the fetch stage
module tb_fetch_unit;
   import fetch_unit_pkg::*;
   localparam int PW = DEF_PC_W;
   localparam int OW = DEF_OFF_W;
   localparam int CW = DEF_CNT_W;
   logic CLK = 1'b0, reset = 1'b1, start = 1'b0, branch = 1'b0, halt = 1'b0, cond_flag = 1'b0;
   logic [PW-1:0] start_addr = '0;
   logic [OW-1:0] branch_off = '0;
   logic [PW-1:0] imem_addr, pc;
   logic fetch_valid, done;
   logic [CW-1:0] instr_count;
   int checks = 0, errors = 0;
   int m_mode = 0, m_pc = 0, m_cnt = 0;
   bit armed = 0;

   fetch_unit dut (
      .CLK(CLK), .reset(reset), .start(start), .start_addr(start_addr),
      .branch(branch), .halt(halt), .cond_flag(cond_flag), .branch_off(branch_off),
      .imem_addr(imem_addr), .pc(pc), .fetch_valid(fetch_valid), .done(done),
      .instr_count(instr_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic int sext(input logic [OW-1:0] v);
      int o = int'(v);
      return (o >= (1 << (OW - 1))) ? o - (1 << OW) : o;
   endfunction

   // model: mode 0 idle, 1 running, 2 halted; pc and count as plain integers
   always @(posedge CLK) begin
      if (reset) begin
         m_mode = 0; m_pc = 0; m_cnt = 0; armed = 1;
      end else if (m_mode == 1) begin
         if (m_cnt < (1 << CW) - 1) m_cnt++;
         if (halt) m_mode = 2;
         else m_pc = (m_pc + ((branch && cond_flag) ? sext(branch_off) : 1) + (1 << PW)) % (1 << PW);
      end else if (start) begin
         m_mode = 1; m_pc = int'(start_addr); m_cnt = 0;
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge CLK) if (armed) begin
      chk("m_pc", 32'(pc), 32'(m_pc));
      chk("m_imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("m_fetch_valid", 32'(fetch_valid), 32'(m_mode == 1));
      chk("m_done", 32'(done), 32'(m_mode == 2));
      chk("m_count", 32'(instr_count), 32'(m_cnt));
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #2;
      end
   endtask

   task automatic restart(input logic [PW-1:0] a);
      reset = 1; branch = 0; cond_flag = 0; halt = 0; cyc();
      reset = 0; start = 1; start_addr = a; cyc();
      start = 0;
   endtask

   initial begin
      cyc(2);
      reset = 0;
      chk("reset_pc", 32'(pc), 32'h0);
      chk("reset_fv", 32'(fetch_valid), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      cyc(2);
      chk("idle_hold_pc", 32'(pc), 32'h0);
      // reset held two cycles mid-run at pc 0x05
      start = 1; start_addr = 10'h002; cyc(); start = 0;
      cyc(3);
      chk("pre_reset_pc", 32'(pc), 32'h005);
      reset = 1; cyc(2); reset = 0;
      chk("midrun_reset_pc", 32'(pc), 32'h0);
      chk("midrun_reset_fv", 32'(fetch_valid), 32'h0);
      chk("midrun_reset_done", 32'(done), 32'h0);
      chk("midrun_reset_cnt", 32'(instr_count), 32'h0);
      // sequential fetch from 0x010
      start = 1; start_addr = 10'h010; cyc(); start = 0;
      chk("start_pc", 32'(pc), 32'h010);
      chk("start_fv", 32'(fetch_valid), 32'h1);
      cyc(4);
      chk("seq_pc", 32'(pc), 32'h014);
      chk("seq_cnt", 32'(instr_count), 32'h4);
      // taken and not-taken branch
      restart(10'h020);
      branch = 1; cond_flag = 1; branch_off = 7'h7D; cyc();
      chk("br_taken_pc", 32'(pc), 32'h01D);
      restart(10'h020);
      branch = 1; cond_flag = 0; branch_off = 7'h7D; cyc();
      chk("br_nottaken_pc", 32'(pc), 32'h021);
      // wrap in both directions
      restart(10'h3FF);
      cyc();
      chk("wrap_up_pc", 32'(pc), 32'h000);
      restart(10'h001);
      branch = 1; cond_flag = 1; branch_off = 7'h7E; cyc();
      chk("wrap_down_pc", 32'(pc), 32'h3FF);
      branch = 1; cond_flag = 1; branch_off = 7'h3F; cyc();
      chk("pos_off_pc", 32'(pc), 32'h03E);
      // halt beats branch, state frozen, restart from halted
      restart(10'h030);
      halt = 1; branch = 1; cond_flag = 1; branch_off = 7'h05; cyc();
      halt = 0;
      chk("halt_pc", 32'(pc), 32'h030);
      chk("halt_done", 32'(done), 32'h1);
      chk("halt_fv", 32'(fetch_valid), 32'h0);
      chk("halt_cnt", 32'(instr_count), 32'h1);
      cyc(3);
      chk("frozen_pc", 32'(pc), 32'h030);
      chk("frozen_cnt", 32'(instr_count), 32'h1);
      start = 1; start_addr = 10'h000; branch = 0; cyc(); start = 0;
      chk("rerun_pc", 32'(pc), 32'h000);
      chk("rerun_cnt", 32'(instr_count), 32'h0);
      chk("rerun_done", 32'(done), 32'h0);
      chk("rerun_fv", 32'(fetch_valid), 32'h1);
      // start ignored while running; zero offset self-loop
      start = 1; start_addr = 10'h155; branch = 1; cond_flag = 1; branch_off = 7'h00; cyc(3);
      start = 0;
      chk("selfloop_pc", 32'(pc), 32'h000);
      chk("selfloop_cnt", 32'(instr_count), 32'h3);
      branch = 0; cond_flag = 0; cyc(2);
      chk("resume_pc", 32'(pc), 32'h002);
      @(negedge CLK);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
